// File: rtl/alu_result_packer_pkg.sv
// Shared types and constants for the ALU result packer.
// Optional checksum feature: ALU_RESULT_PACKER_CSUM_EN.
package alu_pkt_pkg;

    localparam int RES_W_DEF   = 16;
    localparam int ENTRIES_DEF = 256;
    localparam int SEQ_W       = 8;
    localparam int OVF_W       = 16;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

endpackage

// File: rtl/alu_result_packer_if.sv
// Result-in / frame-out bundle of the ALU result packer.
// master = producer and frame consumer side, slave = packer.
interface alu_result_packer_if #(
    parameter int ENTRIES = alu_pkt_pkg::ENTRIES_DEF,
    parameter int RES_W   = alu_pkt_pkg::RES_W_DEF
);
    import alu_pkt_pkg::*;

    localparam int CNT_W = $clog2(ENTRIES) + 1;

    logic                     done_i;
    logic [RES_W-1:0]         result_i;
    logic                     flush_i;
    logic                     frame_valid_o;
    logic                     frame_ready_i;
    logic [ENTRIES*RES_W-1:0] frame_data_o;
    logic [CNT_W-1:0]         frame_count_o;
    logic [SEQ_W-1:0]         frame_seq_o;
    logic [RES_W-1:0]         frame_csum_o;
    logic [OVF_W-1:0]         overflow_cnt_o;

    modport master (
        output done_i, result_i, flush_i, frame_ready_i,
        input  frame_valid_o, frame_data_o, frame_count_o, frame_seq_o,
               frame_csum_o, overflow_cnt_o
    );

    modport slave (
        input  done_i, result_i, flush_i, frame_ready_i,
        output frame_valid_o, frame_data_o, frame_count_o, frame_seq_o,
               frame_csum_o, overflow_cnt_o
    );

endinterface

// File: rtl/alu_result_packer_bank.sv
// One ping-pong bank: storage, fill count, state and optional running XOR.
// Optional checksum feature: ALU_RESULT_PACKER_CSUM_EN.
// Next-state values are exported so the top can register its outputs
// from the value each bank will hold after the current edge.
//
//   state        | meaning
//   BANK_EMPTY   | zeroed, waiting to be opened for filling
//   BANK_FILLING | the fill bank, accepting writes at index count
//   BANK_FULL    | closed frame waiting to be presented/accepted
module alu_result_bank
    import alu_pkt_pkg::*;
#(
    parameter int ENTRIES   = ENTRIES_DEF,
    parameter int RES_W     = RES_W_DEF,
    parameter bit INIT_FILL = 1'b0,
    localparam int CNT_W    = $clog2(ENTRIES) + 1,
    localparam int IDX_W    = $clog2(ENTRIES)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_wr,
    input  logic [RES_W-1:0]         i_wr_data,
    input  logic                     i_close,
    input  logic                     i_clear,
    input  logic                     i_open,
    output bank_state_e              o_state,
    output bank_state_e              o_state_nxt,
    output logic [CNT_W-1:0]         o_count_nxt,
    output logic [ENTRIES*RES_W-1:0] o_data_nxt,
    output logic                     o_going_full
`ifdef ALU_RESULT_PACKER_CSUM_EN
    ,
    output logic [RES_W-1:0]         o_csum_nxt
`endif
);

    bank_state_e              r_state;
    logic [CNT_W-1:0]         r_count;
    logic [ENTRIES*RES_W-1:0] r_data;
    logic [CNT_W-1:0]         w_cnt_wr;
`ifdef ALU_RESULT_PACKER_CSUM_EN
    logic [RES_W-1:0]         r_csum;
`endif

    assign o_state = r_state;

    // Detect closure from write/close alone so it never depends on open/clear.
    always_comb begin
        w_cnt_wr     = r_count + CNT_W'(i_wr);
        o_going_full = (r_state == BANK_FILLING) &&
                       ((w_cnt_wr == CNT_W'(ENTRIES)) || (i_close && (w_cnt_wr != '0)));
    end

    // Next contents of the bank: clear/open wins, otherwise write and close while filling.
    always_comb begin
        o_state_nxt = r_state;
        o_count_nxt = r_count;
        o_data_nxt  = r_data;
`ifdef ALU_RESULT_PACKER_CSUM_EN
        o_csum_nxt  = r_csum;
`endif
        if (i_clear || i_open) begin
            o_state_nxt = i_open ? BANK_FILLING : BANK_EMPTY;
            o_count_nxt = '0;
            o_data_nxt  = '0;
`ifdef ALU_RESULT_PACKER_CSUM_EN
            o_csum_nxt  = '0;
`endif
        end else if (r_state == BANK_FILLING) begin
            if (i_wr) begin
                o_data_nxt[int'(r_count[IDX_W-1:0])*RES_W +: RES_W] = i_wr_data;
`ifdef ALU_RESULT_PACKER_CSUM_EN
                o_csum_nxt = r_csum ^ i_wr_data;
`endif
            end
            o_count_nxt = w_cnt_wr;
            if (o_going_full) begin
                o_state_nxt = BANK_FULL;
            end
        end
    end

    // Bank registers; reset discards any partial or pending frame.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= INIT_FILL ? BANK_FILLING : BANK_EMPTY;
            r_count <= '0;
            r_data  <= '0;
`ifdef ALU_RESULT_PACKER_CSUM_EN
            r_csum  <= '0;
`endif
        end else begin
            r_state <= o_state_nxt;
            r_count <= o_count_nxt;
            r_data  <= o_data_nxt;
`ifdef ALU_RESULT_PACKER_CSUM_EN
            r_csum  <= o_csum_nxt;
`endif
        end
    end

endmodule

// File: rtl/alu_result_packer.sv
// Packs ALU results LSB-first into ENTRIES-word frames using two ping-pong
// banks and presents closed frames over a valid/ready handshake.
// Optional checksum feature: ALU_RESULT_PACKER_CSUM_EN (frame_csum_o is 0 without it).
// Banks fill and close strictly alternately, so the oldest FULL bank is always
// r_head, which simply toggles on every acceptance.
module alu_result_packer
    import alu_pkt_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF,
    parameter int RES_W   = RES_W_DEF
) (
    input  logic                clk_i,
    input  logic                reset_i,
    alu_result_packer_if.slave  bus
);

    localparam int CNT_W = $clog2(ENTRIES) + 1;

    bank_state_e              w_state     [2];
    bank_state_e              w_state_nxt [2];
    logic [CNT_W-1:0]         w_count_nxt [2];
    logic [ENTRIES*RES_W-1:0] w_data_nxt  [2];
    logic [1:0]               w_going_full;
    logic [1:0]               w_wr;
    logic [1:0]               w_close;
    logic [1:0]               w_clear;
    logic [1:0]               w_open;

    logic                     r_fill_sel;
    logic                     r_fill_act;
    logic                     r_head;
    logic                     w_fill_sel_nxt;
    logic                     w_fill_act_nxt;
    logic                     w_other;
    logic                     w_accept;
    logic                     w_head_nxt;
    logic                     w_pres_full;

    logic                     r_frame_valid;
    logic [ENTRIES*RES_W-1:0] r_frame_data;
    logic [CNT_W-1:0]         r_frame_count;
    logic [SEQ_W-1:0]         r_seq;
    logic [OVF_W-1:0]         r_ovf;
`ifdef ALU_RESULT_PACKER_CSUM_EN
    logic [RES_W-1:0]         w_csum_nxt [2];
    logic [RES_W-1:0]         r_frame_csum;
`endif

    alu_result_bank #(.ENTRIES(ENTRIES), .RES_W(RES_W), .INIT_FILL(1'b1)) u_bank_a (
        .i_clk        (clk_i),
        .i_reset      (reset_i),
        .i_wr         (w_wr[0]),
        .i_wr_data    (bus.result_i),
        .i_close      (w_close[0]),
        .i_clear      (w_clear[0]),
        .i_open       (w_open[0]),
        .o_state      (w_state[0]),
        .o_state_nxt  (w_state_nxt[0]),
        .o_count_nxt  (w_count_nxt[0]),
        .o_data_nxt   (w_data_nxt[0]),
        .o_going_full (w_going_full[0])
`ifdef ALU_RESULT_PACKER_CSUM_EN
        ,
        .o_csum_nxt   (w_csum_nxt[0])
`endif
    );

    alu_result_bank #(.ENTRIES(ENTRIES), .RES_W(RES_W), .INIT_FILL(1'b0)) u_bank_b (
        .i_clk        (clk_i),
        .i_reset      (reset_i),
        .i_wr         (w_wr[1]),
        .i_wr_data    (bus.result_i),
        .i_close      (w_close[1]),
        .i_clear      (w_clear[1]),
        .i_open       (w_open[1]),
        .o_state      (w_state[1]),
        .o_state_nxt  (w_state_nxt[1]),
        .o_count_nxt  (w_count_nxt[1]),
        .o_data_nxt   (w_data_nxt[1]),
        .o_going_full (w_going_full[1])
`ifdef ALU_RESULT_PACKER_CSUM_EN
        ,
        .o_csum_nxt   (w_csum_nxt[1])
`endif
    );

    assign w_accept    = r_frame_valid && bus.frame_ready_i;
    assign w_other     = ~r_fill_sel;
    assign w_head_nxt  = r_head ^ w_accept;
    assign w_pres_full = (w_state_nxt[w_head_nxt] == BANK_FULL);

    // Route writes/flush to the fill bank and drain the presented bank on acceptance.
    always_comb begin
        w_wr    = '0;
        w_close = '0;
        w_clear = '0;
        if (r_fill_act) begin
            w_wr[r_fill_sel]    = bus.done_i;
            w_close[r_fill_sel] = bus.flush_i;
        end
        if (w_accept) begin
            w_clear[r_head] = 1'b1;
        end
    end

    // Choose the next fill bank: swap on closure, or reuse a drained bank when stalled.
    always_comb begin
        w_open         = '0;
        w_fill_sel_nxt = r_fill_sel;
        w_fill_act_nxt = r_fill_act;
        if (r_fill_act && w_going_full[r_fill_sel]) begin
            // The other bank is usable if empty or drained on this very edge.
            if ((w_state[w_other] == BANK_EMPTY) || (w_accept && (r_head == w_other))) begin
                w_open[w_other] = 1'b1;
                w_fill_sel_nxt  = w_other;
            end else begin
                w_fill_act_nxt = 1'b0;
            end
        end else if (!r_fill_act && w_accept) begin
            w_open[r_head] = 1'b1;
            w_fill_sel_nxt = r_head;
            w_fill_act_nxt = 1'b1;
        end
    end

    // Selection state, counters and registered frame outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_fill_sel    <= 1'b0;
            r_fill_act    <= 1'b1;
            r_head        <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_data  <= '0;
            r_frame_count <= '0;
            r_seq         <= '0;
            r_ovf         <= '0;
`ifdef ALU_RESULT_PACKER_CSUM_EN
            r_frame_csum  <= '0;
`endif
        end else begin
            r_fill_sel    <= w_fill_sel_nxt;
            r_fill_act    <= w_fill_act_nxt;
            r_head        <= w_head_nxt;
            r_frame_valid <= w_pres_full;
            r_frame_data  <= w_pres_full ? w_data_nxt[w_head_nxt] : '0;
            r_frame_count <= w_pres_full ? w_count_nxt[w_head_nxt] : '0;
`ifdef ALU_RESULT_PACKER_CSUM_EN
            r_frame_csum  <= w_pres_full ? w_csum_nxt[w_head_nxt] : '0;
`endif
            if (w_accept) begin
                r_seq <= r_seq + 1'b1;
            end
            if (bus.done_i && !r_fill_act && (r_ovf != {OVF_W{1'b1}})) begin
                r_ovf <= r_ovf + 1'b1;
            end
        end
    end

    assign bus.frame_valid_o  = r_frame_valid;
    assign bus.frame_data_o   = r_frame_data;
    assign bus.frame_count_o  = r_frame_count;
    assign bus.frame_seq_o    = r_seq;
    assign bus.overflow_cnt_o = r_ovf;
`ifdef ALU_RESULT_PACKER_CSUM_EN
    assign bus.frame_csum_o   = r_frame_csum;
`else
    assign bus.frame_csum_o   = '0;
`endif

endmodule

// File: tb/tb_alu_result_packer.sv
// Bench for alu_result_packer: directed scenarios with literal expectations
// plus randomized traffic, all checked against a frame-queue reference model.
module tb_alu_result_packer;
    import alu_pkt_pkg::*;

    localparam int ENTRIES = 256;
    localparam int RES_W   = 16;
    localparam int FW      = ENTRIES * RES_W;
`ifdef ALU_RESULT_PACKER_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_result_packer_if #(.ENTRIES(ENTRIES), .RES_W(RES_W)) bus ();

    alu_result_packer #(.ENTRIES(ENTRIES), .RES_W(RES_W)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: partial frame words plus a queue of closed frames (at most two).
    logic [RES_W-1:0] m_cur [$];
    logic [FW-1:0]    m_pd  [$];
    int               m_pc  [$];
    logic [RES_W-1:0] m_pcs [$];
    int               m_seq = 0;
    int               m_ovf = 0;

    task automatic close_frame();
        logic [FW-1:0]    v;
        logic [RES_W-1:0] x;
        v = '0;
        x = '0;
        for (int i = 0; i < m_cur.size(); i++) begin
            v[i*RES_W +: RES_W] = m_cur[i];
            x = x ^ m_cur[i];
        end
        m_pd.push_back(v);
        m_pc.push_back(m_cur.size());
        m_pcs.push_back(x);
        m_cur.delete();
    endtask

    always @(posedge clk) begin
        bit acc;
        if (reset) begin
            m_cur.delete();
            m_pd.delete();
            m_pc.delete();
            m_pcs.delete();
            m_seq = 0;
            m_ovf = 0;
        end else begin
            acc = (m_pd.size() > 0) && bus.frame_ready_i;
            if (m_pd.size() < 2) begin
                if (bus.done_i) m_cur.push_back(bus.result_i);
                if ((m_cur.size() == ENTRIES) || (bus.flush_i && (m_cur.size() > 0))) close_frame();
            end else if (bus.done_i && (m_ovf < 65535)) begin
                m_ovf++;
            end
            if (acc) begin
                void'(m_pd.pop_front());
                void'(m_pc.pop_front());
                void'(m_pcs.pop_front());
                m_seq = (m_seq + 1) % 256;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_data(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            for (int i = 0; i < ENTRIES; i++) begin
                if (act[i*RES_W +: RES_W] !== exp[i*RES_W +: RES_W]) begin
                    $display("FAIL %s entry=%0d actual=%0h required=%0h", nm, i,
                             act[i*RES_W +: RES_W], exp[i*RES_W +: RES_W]);
                    break;
                end
            end
        end
    endtask

    function automatic logic [RES_W-1:0] ent(input logic [FW-1:0] v, input int k);
        return v[k*RES_W +: RES_W];
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            bit v;
            v = (m_pd.size() > 0);
            chk("m_valid", 32'(bus.frame_valid_o), 32'(v));
            chk_data("m_data", bus.frame_data_o, v ? m_pd[0] : '0);
            chk("m_count", 32'(bus.frame_count_o), v ? 32'(m_pc[0]) : 32'd0);
            chk("m_csum", 32'(bus.frame_csum_o), (v && CSUM_ON) ? 32'(m_pcs[0]) : 32'd0);
            chk("m_seq", 32'(bus.frame_seq_o), 32'(m_seq));
            chk("m_ovf", 32'(bus.overflow_cnt_o), 32'(m_ovf));
        end
    end

    task automatic cyc(input bit d, input logic [RES_W-1:0] r, input bit f, input bit rdy);
        @(negedge clk);
        bus.done_i        = d;
        bus.result_i      = r;
        bus.flush_i       = f;
        bus.frame_ready_i = rdy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.done_i = 1'b0; bus.flush_i = 1'b0; bus.frame_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [FW-1:0] snap;

    initial begin
        bus.done_i = 1'b0;
        bus.result_i = '0;
        bus.flush_i = 1'b0;
        bus.frame_ready_i = 1'b0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(bus.frame_valid_o), 32'd0);
        chk("rst_count", 32'(bus.frame_count_o), 32'd0);
        chk("rst_seq", 32'(bus.frame_seq_o), 32'd0);
        chk("rst_ovf", 32'(bus.overflow_cnt_o), 32'd0);
        chk("rst_csum", 32'(bus.frame_csum_o), 32'd0);
        chk("rst_data_zero", 32'(bus.frame_data_o != '0), 32'd0);
        reset = 1'b0;

        // Full frame of k = 0..255.
        for (int k = 0; k < ENTRIES; k++) cyc(1'b1, 16'(k), 1'b0, 1'b0);
        chk("ff_valid_before", 32'(bus.frame_valid_o), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        snap = bus.frame_data_o;
        chk("ff_valid", 32'(bus.frame_valid_o), 32'd1);
        chk("ff_count", 32'(bus.frame_count_o), 32'd256);
        chk("ff_seq", 32'(bus.frame_seq_o), 32'd0);
        chk("ff_e0", 32'(ent(snap, 0)), 32'h0000);
        chk("ff_e128", 32'(ent(snap, 128)), 32'h0080);
        chk("ff_e255", 32'(ent(snap, 255)), 32'h00FF);
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("ff_drained", 32'(bus.frame_valid_o), 32'd0);
        chk("ff_seq_after", 32'(bus.frame_seq_o), 32'd1);

        // Partial flush.
        cyc(1'b1, 16'h1111, 1'b0, 1'b0);
        cyc(1'b1, 16'h2222, 1'b0, 1'b0);
        cyc(1'b1, 16'h3333, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        snap = bus.frame_data_o;
        chk("pf_count", 32'(bus.frame_count_o), 32'd3);
        chk("pf_lo", snap[31:0], 32'h2222_1111);
        chk("pf_hi", 32'(snap[47:32]), 32'h3333);
        chk("pf_upper_zero", 32'(snap[FW-1:48] != '0), 32'd0);
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("pf_empty_flush_ignored", 32'(bus.frame_valid_o), 32'd0);

        // done and flush in the same cycle.
        cyc(1'b1, 16'h000A, 1'b0, 1'b0);
        cyc(1'b1, 16'h000B, 1'b0, 1'b0);
        cyc(1'b1, 16'h00FF, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        snap = bus.frame_data_o;
        chk("df_count", 32'(bus.frame_count_o), 32'd3);
        chk("df_e2", 32'(ent(snap, 2)), 32'h00FF);
        chk("df_e0", 32'(ent(snap, 0)), 32'h000A);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Checksum.
        cyc(1'b1, 16'h0F0F, 1'b0, 1'b0);
        cyc(1'b1, 16'h00FF, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("cs_csum", 32'(bus.frame_csum_o), CSUM_ON ? 32'h0FF0 : 32'd0);
        chk("cs_count", 32'(bus.frame_count_o), 32'd2);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Backpressure and overflow from a fresh reset.
        do_reset();
        for (int k = 0; k < 517; k++) cyc(1'b1, 16'(k), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("bp_ovf", 32'(bus.overflow_cnt_o), 32'd5);
        chk("bp_seq0", 32'(bus.frame_seq_o), 32'd0);
        chk("bp_count0", 32'(bus.frame_count_o), 32'd256);
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        snap = bus.frame_data_o;
        chk("bp_b2b_valid", 32'(bus.frame_valid_o), 32'd1);
        chk("bp_seq1", 32'(bus.frame_seq_o), 32'd1);
        chk("bp_count1", 32'(bus.frame_count_o), 32'd256);
        chk("bp_f1_e0", 32'(ent(snap, 0)), 32'h0100);
        chk("bp_f1_e255", 32'(ent(snap, 255)), 32'h01FF);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("bp_done_valid", 32'(bus.frame_valid_o), 32'd0);
        chk("bp_seq2", 32'(bus.frame_seq_o), 32'd2);

        // Reset mid-fill.
        for (int k = 0; k < 100; k++) cyc(1'b1, 16'(16'h4000 + k), 1'b0, 1'b0);
        do_reset();
        for (int k = 0; k < ENTRIES; k++) cyc(1'b1, 16'(16'h5000 + k), 1'b0, 1'b0);
        chk("rm_no_frame", 32'(bus.frame_valid_o), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        snap = bus.frame_data_o;
        chk("rm_seq", 32'(bus.frame_seq_o), 32'd0);
        chk("rm_count", 32'(bus.frame_count_o), 32'd256);
        chk("rm_e0", 32'(ent(snap, 0)), 32'h5000);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Randomized traffic in segments with different ready/flush pressure.
        for (int seg = 0; seg < 4; seg++) begin
            int rdy_pct, fl_pct;
            rdy_pct = (seg == 0) ? 50 : (seg == 1) ? 5 : (seg == 2) ? 90 : 30;
            fl_pct  = (seg == 2) ? 0 : 4;
            for (int c = 0; c < 1500; c++) begin
                cyc($urandom_range(0, 99) < 75, 16'($urandom), $urandom_range(0, 99) < fl_pct,
                    $urandom_range(0, 99) < rdy_pct);
                if ($urandom_range(0, 999) == 0) reset = 1'b1;
                else reset = 1'b0;
            end
        end
        cyc(1'b0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        cyc(1'b0, '0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_packer.md
# alu_result_packer

Downstream collector for the tinyalu stimulus bench. It samples each completed ALU result (`done_i` pulse plus `result_i`) and packs results LSB-first into wide frames of `ENTRIES` words. It uses two ping-pong banks so the ALU never stalls, and hands full or flushed frames to the host-side DPI consumer over a valid/ready handshake. This mirrors the wide-vector packet format the stimulus side uses for commands.

## Interface
Parameters:
- `ENTRIES`, 256: results per frame.
- `RES_W`, 16: result width.

Ports:
- `clk_i` in 1: sole clock; all logic on its rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `done_i` in 1: one-cycle ALU completion pulse; `result_i` is valid in the same cycle.
- `result_i` in `RES_W`: ALU result.
- `flush_i` in 1: close the current partial frame.
- `frame_valid_o` out 1: a frame is presented.
- `frame_ready_i` in 1: the consumer accepts the frame.
- `frame_data_o` out `ENTRIES*RES_W`: entry k at bits `[k*RES_W +: RES_W]`; unused entries read 0.
- `frame_count_o` out 9 (`$clog2(ENTRIES)+1`): number of valid entries in the presented frame.
- `frame_seq_o` out 8: frame sequence number.
- `frame_csum_o` out `RES_W`: checksum (see Configuration).
- `overflow_cnt_o` out 16: count of dropped results.

## Operation
- Two banks, A and B. Each bank is in one of three states: EMPTY, FILLING, FULL.
  - Exactly one bank is the fill bank; after reset that is A, in state FILLING.
- **Capture:** when `done_i`=1 and the fill bank is FILLING, write `result_i` at index `count`, then do `count++`.
  - When `count` reaches `ENTRIES`, the bank goes to FULL.
- **Bank swap:** when the fill bank goes FULL and the other bank is EMPTY, the other bank becomes the fill bank (state FILLING, `count`=0) on the same edge.
  - If the other bank is FULL, there is no fill bank until a drain frees one.
  - Any `done_i` arriving with no fill bank is dropped, and `overflow_cnt_o` increments, saturating at 0xFFFF.
- **Flush:** if `flush_i`=1 and the fill bank has `count`≥1, the bank goes to FULL with its current count, and the bank swap rule applies.
  - `flush_i` with `count`=0 is ignored.
  - `done_i` and `flush_i` in the same cycle: the result is written first and is included in the flushed frame.
- **Presentation:** the oldest FULL bank is presented.
  - A frame is accepted on an edge where `frame_valid_o` && `frame_ready_i`.
  - On acceptance the bank is cleared to EMPTY with its data zeroed, and `frame_seq_o` increments, wrapping 255→0.
  - If there is no fill bank at that moment, the drained bank becomes the fill bank.
- `frame_data_o`, `frame_count_o` and `frame_csum_o` are stable while `frame_valid_o`=1 and not yet accepted.

## Timing
- **Reset:** `frame_valid_o`=0, `frame_data_o`=0, `frame_count_o`=0, `frame_seq_o`=0, `frame_csum_o`=0, `overflow_cnt_o`=0. A=FILLING, B=EMPTY.
  - Asserting reset mid-fill discards all partial and pending frames.
- **Latency:** all outputs are registered.
  - `frame_valid_o` rises 1 cycle after the edge on which a bank becomes FULL (the edge capturing the last entry, or the flush edge).
- **Back-to-back frames:** if the other bank is FULL when a frame is accepted, `frame_valid_o` stays high and the new frame's data appears the cycle after acceptance.
- Results may arrive every cycle. Capture never depends on `frame_ready_i` while a fill bank exists.

## Configuration
- `ALU_RESULT_PACKER_CSUM_EN` defined: each bank keeps a running XOR of its written entries, and `frame_csum_o` presents the XOR of the presented frame.
- Undefined: no checksum logic is built, and `frame_csum_o` is tied to 0.

## Structure
- Package `alu_pkt_pkg` holds:
  - defaults for `RES_W` and `ENTRIES`;
  - the bank-state enum (EMPTY/FILLING/FULL);
  - the `SEQ_W`=8 and `OVF_W`=16 constants.
- One sub-module, `alu_result_bank`, is instantiated twice. It holds the storage, count, state and optional XOR, and has write, close and clear controls. The top level holds the fill/present selection, sequence and overflow counters.

## Test plan
- **Full frame:** reset, then 256 `done_i` pulses with `result_i`=k for k=0..255 → one frame with entry k=k, count=256, seq=0, `frame_valid_o` rising 1 cycle after the last pulse.
- **Partial flush:** results 0x1111, 0x2222, 0x3333, then `flush_i` → count=3, `frame_data_o[47:0]`=0x333322221111, upper bits 0.
- **Backpressure and overflow:** hold `frame_ready_i`=0 and send 517 results → 5 dropped, `overflow_cnt_o`=5. Then raise ready → frames seq 0 and 1 delivered back-to-back, each with count=256.
- **Simultaneous done and flush:** two results, then `done_i`+`flush_i` in the same cycle with 0x00FF → count=3, entry 2=0x00FF.
- **Reset mid-fill:** reset after 100 results → no frame appears. The next 256 results start at entry 0, seq=0.
- **Checksum:** with `ALU_RESULT_PACKER_CSUM_EN`, results 0x0F0F, 0x00FF, then flush → `frame_csum_o`=0x0FF0. Without the macro, `frame_csum_o`=0.
